// File: rtl/cfg_reg_bank.sv
// ---------------------------------------------------------------------------
// cfg_reg_bank
//
// Purpose:
//   Parametrised configuration register bank for the switch. A host reaches
//   the registers through an addressed read/write slave port with a
//   request/acknowledge handshake. Each register has its own reset value.
//   A lock register can refuse configuration writes. Each register has a
//   one-cycle update strobe for the switch port logic.
//
//   Transaction flow (IDLE -> ACCESS -> DONE -> IDLE):
//     - The request is sampled in IDLE. The command is latched on that edge.
//     - The latched command executes in ACCESS. Ack, error and read data are
//       registered on the same edge as the register update.
//     - DONE takes one dead cycle, so a request that is still held high
//       cannot retrigger immediately.
//
// Ports:
//   clk           in   1                    rising-edge clock
//   rst_n         in   1                    asynchronous active-low reset
//   sw_en         in   1                    transaction request, held until ack
//   sw_wr_rd      in   1                    1 = write, 0 = read
//   sw_addr       in   ADDR_WIDTH           register address
//   sw_wdata      in   W_WIDTH              write data
//   sw_rdata      out  W_WIDTH              read data, valid while sw_ack = 1
//   sw_ack        out  1                    one-cycle completion pulse
//   sw_err        out  1                    error flag, valid while sw_ack = 1
//   reg_data_out  out  NUM_OF_REG*W_WIDTH   flat register contents
//   reg_upd       out  NUM_OF_REG           per-register write strobe
// ---------------------------------------------------------------------------
module cfg_reg_bank #(
    parameter int                              NUM_OF_REG = 4,
    parameter int                              W_WIDTH    = 8,
    parameter int                              ADDR_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0]           LOCK_ADDR  = {ADDR_WIDTH{1'b1}},
    parameter logic [NUM_OF_REG*W_WIDTH-1:0]   RST_VAL    = '0
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               sw_en,
    input  logic                               sw_wr_rd,
    input  logic [ADDR_WIDTH-1:0]              sw_addr,
    input  logic [W_WIDTH-1:0]                 sw_wdata,
    output logic [W_WIDTH-1:0]                 sw_rdata,
    output logic                               sw_ack,
    output logic                               sw_err,
    output logic [NUM_OF_REG*W_WIDTH-1:0]      reg_data_out,
    output logic [NUM_OF_REG-1:0]              reg_upd
);

    // Data values written to the lock register.
    localparam logic [W_WIDTH-1:0]    LOCK_KEY   = W_WIDTH'(8'hA5);
    localparam logic [W_WIDTH-1:0]    UNLOCK_KEY = '0;
    localparam logic [ADDR_WIDTH:0]   NUM_REG_EXT = (ADDR_WIDTH+1)'(NUM_OF_REG);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t                     r_state;
    state_t                     w_state_next;

    // Command latched when the request is accepted.
    logic                       r_wr;
    logic [ADDR_WIDTH-1:0]      r_addr;
    logic [W_WIDTH-1:0]         r_wdata;

    logic                       r_locked;
    logic                       r_ack;
    logic                       r_err;
    logic [W_WIDTH-1:0]         r_rdata;
    logic [NUM_OF_REG-1:0]      r_upd;

    logic                       w_exec;
    logic                       w_addr_is_reg;
    logic                       w_addr_is_lock;
    logic                       w_err;
    logic [W_WIDTH-1:0]         w_rdata;
    logic [W_WIDTH-1:0]         w_reg_rdata;
    logic [NUM_OF_REG-1:0]      w_wr_en;
    logic [W_WIDTH-1:0]         w_regs [NUM_OF_REG];

    // -----------------------------------------------------------------------
    // FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (sw_en) w_state_next = ACCESS;
            ACCESS:  w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Latch the command when the request is accepted. After that the host
    // may change the address, data or direction freely.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (r_state == IDLE && sw_en) begin
            r_wr    <= sw_wr_rd;
            r_addr  <= sw_addr;
            r_wdata <= sw_wdata;
        end
    end

    // -----------------------------------------------------------------------
    // Address decode and command evaluation (valid during ACCESS)
    // -----------------------------------------------------------------------
    assign w_exec         = (r_state == ACCESS);
    assign w_addr_is_reg  = ({1'b0, r_addr} < NUM_REG_EXT);
    assign w_addr_is_lock = (r_addr == LOCK_ADDR);

    // Read mux across the register array.
    always_comb begin
        w_reg_rdata = '0;
        for (int i = 0; i < NUM_OF_REG; i++) begin
            if (r_addr == ADDR_WIDTH'(i)) begin
                w_reg_rdata = w_regs[i];
            end
        end
    end

    always_comb begin
        w_err   = 1'b0;
        w_rdata = '0;
        if (w_addr_is_reg) begin
            // Reads are still allowed while the bank is locked.
            w_err = r_wr && r_locked;
            if (!r_wr) w_rdata = w_reg_rdata;
        end else if (w_addr_is_lock) begin
            if (!r_wr) w_rdata = {{(W_WIDTH-1){1'b0}}, r_locked};
        end else begin
            w_err = 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Register array. Each register gets its own flop group and reset value.
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_OF_REG; gi++) begin : g_reg
            logic [W_WIDTH-1:0] r_reg;

            assign w_wr_en[gi] = w_exec && r_wr && !r_locked &&
                                 (r_addr == ADDR_WIDTH'(gi));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_reg <= RST_VAL[gi*W_WIDTH +: W_WIDTH];
                end else if (w_wr_en[gi]) begin
                    r_reg <= r_wdata;
                end
            end

            assign w_regs[gi]                             = r_reg;
            assign reg_data_out[gi*W_WIDTH +: W_WIDTH]    = r_reg;
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Lock register. A lock write is never refused. The new lock state only
    // affects later transactions, because the write path above sees the
    // pre-edge value of r_locked.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_locked <= 1'b0;
        end else if (w_exec && r_wr && w_addr_is_lock) begin
            if (r_wdata == LOCK_KEY) begin
                r_locked <= 1'b1;
            end else if (r_wdata == UNLOCK_KEY) begin
                r_locked <= 1'b0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Response registers. These are non-zero only in the cycle after ACCESS.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
            r_upd   <= '0;
        end else if (w_exec) begin
            r_ack   <= 1'b1;
            r_err   <= w_err;
            r_rdata <= w_rdata;
            r_upd   <= w_wr_en;
        end else begin
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
            r_upd   <= '0;
        end
    end

    assign sw_ack   = r_ack;
    assign sw_err   = r_err;
    assign sw_rdata = r_rdata;
    assign reg_upd  = r_upd;

endmodule

// File: tb/tb_cfg_reg_bank.sv
// ---------------------------------------------------------------------------
// tb_cfg_reg_bank
//
// Directed bench for cfg_reg_bank with 4 x 8-bit registers and
// RST_VAL = 32'h44332211. Each scenario task drives its own stimulus and
// checks its own results. Outputs are sampled 1 ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_cfg_reg_bank;

    localparam int NREG = 4;
    localparam int W    = 8;
    localparam int AW   = 8;
    localparam logic [NREG*W-1:0] RV = 32'h44332211;

    logic              clk;
    logic              rst_n;
    logic              sw_en;
    logic              sw_wr_rd;
    logic [AW-1:0]     sw_addr;
    logic [W-1:0]      sw_wdata;
    logic [W-1:0]      sw_rdata;
    logic              sw_ack;
    logic              sw_err;
    logic [NREG*W-1:0] reg_data_out;
    logic [NREG-1:0]   reg_upd;

    int vectors;
    int miscompares;

    cfg_reg_bank #(
        .NUM_OF_REG (NREG),
        .W_WIDTH    (W),
        .ADDR_WIDTH (AW),
        .LOCK_ADDR  (8'hFF),
        .RST_VAL    (RV)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sw_en        (sw_en),
        .sw_wr_rd     (sw_wr_rd),
        .sw_addr      (sw_addr),
        .sw_wdata     (sw_wdata),
        .sw_rdata     (sw_rdata),
        .sw_ack       (sw_ack),
        .sw_err       (sw_err),
        .reg_data_out (reg_data_out),
        .reg_upd      (reg_upd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Runs one transaction: request on edge k, then sample at k+1 (ack
    // cycle) and at k+2 (after ack). Returns what was observed.
    task automatic run_txn(input logic wr, input logic [AW-1:0] addr,
                           input logic [W-1:0] wdata,
                           output logic ack1, output logic err1,
                           output logic [W-1:0] rdata1,
                           output logic [NREG-1:0] upd1,
                           output logic [NREG*W-1:0] regs1,
                           output logic ack2, output logic [NREG-1:0] upd2);
        @(negedge clk);
        sw_en    = 1'b1;
        sw_wr_rd = wr;
        sw_addr  = addr;
        sw_wdata = wdata;
        @(posedge clk); #1;
        sw_en = 1'b0;
        @(posedge clk); #1;
        ack1   = sw_ack;
        err1   = sw_err;
        rdata1 = sw_rdata;
        upd1   = reg_upd;
        regs1  = reg_data_out;
        @(posedge clk); #1;
        ack2 = sw_ack;
        upd2 = reg_upd;
        $display("txn wr=%0b addr=%02h wdata=%02h -> ack=%0b err=%0b rdata=%02h upd=%04b regs=%08h",
                 wr, addr, wdata, ack1, err1, rdata1, upd1, regs1);
    endtask

    task automatic test_reset();
        logic a1, e1, a2;
        logic [W-1:0] rd;
        logic [NREG-1:0] u1, u2;
        logic [NREG*W-1:0] rg;
        rst_n = 1'b0;
        sw_en = 1'b0; sw_wr_rd = 1'b0; sw_addr = '0; sw_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (reg_data_out !== 32'h44332211) begin
            miscompares++;
            $display("FAIL reset_regs got=%08h exp=%08h", reg_data_out, 32'h44332211);
        end
        vectors++;
        if ({sw_ack, sw_err, sw_rdata, reg_upd} !== '0) begin
            miscompares++;
            $display("FAIL reset_outs got ack=%0b err=%0b rdata=%02h upd=%04b exp all 0",
                     sw_ack, sw_err, sw_rdata, reg_upd);
        end
        run_txn(1'b0, 8'hFF, 8'h00, a1, e1, rd, u1, rg, a2, u2);
        vectors++;
        if ({a1, e1, rd} !== {1'b1, 1'b0, 8'h00}) begin
            miscompares++;
            $display("FAIL reset_lock_read got ack=%0b err=%0b rdata=%02h exp ack=1 err=0 rdata=00",
                     a1, e1, rd);
        end
    endtask

    task automatic test_write_read();
        logic a1, e1, a2;
        logic [W-1:0] rd;
        logic [NREG-1:0] u1, u2;
        logic [NREG*W-1:0] rg;
        run_txn(1'b1, 8'h02, 8'h5A, a1, e1, rd, u1, rg, a2, u2);
        vectors++;
        if ({a1, e1, u1} !== {1'b1, 1'b0, 4'b0100}) begin
            miscompares++;
            $display("FAIL wr2_ack got ack=%0b err=%0b upd=%04b exp ack=1 err=0 upd=0100", a1, e1, u1);
        end
        vectors++;
        if (rg !== 32'h445A2211) begin
            miscompares++;
            $display("FAIL wr2_regs got=%08h exp=445a2211", rg);
        end
        vectors++;
        if ({a2, u2} !== 5'b0) begin
            miscompares++;
            $display("FAIL wr2_pulse got ack=%0b upd=%04b one cycle later exp 0", a2, u2);
        end
        run_txn(1'b0, 8'h02, 8'h00, a1, e1, rd, u1, rg, a2, u2);
        vectors++;
        if ({a1, e1, rd, u1} !== {1'b1, 1'b0, 8'h5A, 4'b0000}) begin
            miscompares++;
            $display("FAIL rd2 got ack=%0b err=%0b rdata=%02h upd=%04b exp 1 0 5a 0000", a1, e1, rd, u1);
        end
    endtask

    task automatic test_lock();
        logic a1, e1, a2;
        logic [W-1:0] rd;
        logic [NREG-1:0] u1, u2;
        logic [NREG*W-1:0] rg;
        run_txn(1'b1, 8'hFF, 8'hA5, a1, e1, rd, u1, rg, a2, u2);
        vectors++;
        if ({a1, e1, u1} !== {1'b1, 1'b0, 4'b0000}) begin
            miscompares++;
            $display("FAIL lock_wr got ack=%0b err=%0b upd=%04b exp 1 0 0000", a1, e1, u1);
        end
        run_txn(1'b0, 8'hFF, 8'h00, a1, e1, rd, u1, rg, a2, u2);
        vectors++;
        if (rd !== 8'h01) begin
            miscompares++;
            $display("FAIL lock_rd got=%02h exp=01", rd);
        end
        run_txn(1'b1, 8'h00, 8'h77, a1, e1, rd, u1, rg, a2, u2);
        vectors++;
        if ({a1, e1, u1, rg} !== {1'b1, 1'b1, 4'b0000, 32'h445A2211}) begin
            miscompares++;
            $display("FAIL locked_wr got ack=%0b err=%0b upd=%04b regs=%08h exp 1 1 0000 445a2211",
                     a1, e1, u1, rg);
        end
        run_txn(1'b0, 8'h00, 8'h00, a1, e1, rd, u1, rg, a2, u2);
        vectors++;
        if ({e1, rd} !== {1'b0, 8'h11}) begin
            miscompares++;
            $display("FAIL locked_rd got err=%0b rdata=%02h exp 0 11", e1, rd);
        end
        // A value other than A5/00 must leave the lock set.
        run_txn(1'b1, 8'hFF, 8'h3C, a1, e1, rd, u1, rg, a2, u2);
        run_txn(1'b0, 8'hFF, 8'h00, a1, e1, rd, u1, rg, a2, u2);
        vectors++;
        if (rd !== 8'h01) begin
            miscompares++;
            $display("FAIL lock_other got=%02h exp=01", rd);
        end
        run_txn(1'b1, 8'hFF, 8'h00, a1, e1, rd, u1, rg, a2, u2);
        vectors++;
        if (e1 !== 1'b0) begin
            miscompares++;
            $display("FAIL unlock_wr got err=%0b exp 0", e1);
        end
        run_txn(1'b1, 8'h00, 8'h77, a1, e1, rd, u1, rg, a2, u2);
        vectors++;
        if ({a1, e1, u1, rg} !== {1'b1, 1'b0, 4'b0001, 32'h445A2277}) begin
            miscompares++;
            $display("FAIL unlocked_wr got ack=%0b err=%0b upd=%04b regs=%08h exp 1 0 0001 445a2277",
                     a1, e1, u1, rg);
        end
    endtask

    task automatic test_bad_addr();
        logic a1, e1, a2;
        logic [W-1:0] rd;
        logic [NREG-1:0] u1, u2;
        logic [NREG*W-1:0] rg;
        run_txn(1'b0, 8'h10, 8'h00, a1, e1, rd, u1, rg, a2, u2);
        vectors++;
        if ({a1, e1, rd} !== {1'b1, 1'b1, 8'h00}) begin
            miscompares++;
            $display("FAIL bad_rd got ack=%0b err=%0b rdata=%02h exp 1 1 00", a1, e1, rd);
        end
        run_txn(1'b1, 8'h10, 8'h99, a1, e1, rd, u1, rg, a2, u2);
        vectors++;
        if ({a1, e1, u1, rg} !== {1'b1, 1'b1, 4'b0000, 32'h445A2277}) begin
            miscompares++;
            $display("FAIL bad_wr got ack=%0b err=%0b upd=%04b regs=%08h exp 1 1 0000 445a2277",
                     a1, e1, u1, rg);
        end
        run_txn(1'b1, 8'h04, 8'h99, a1, e1, rd, u1, rg, a2, u2);
        vectors++;
        if ({e1, u1, rg} !== {1'b1, 4'b0000, 32'h445A2277}) begin
            miscompares++;
            $display("FAIL addr4_wr got err=%0b upd=%04b regs=%08h exp 1 0000 445a2277", e1, u1, rg);
        end
    endtask

    task automatic test_back_to_back();
        int ack_cnt;
        int first_at;
        int second_at;
        ack_cnt = 0; first_at = -1; second_at = -1;
        // Hold the write request over 6 sampling edges.
        @(negedge clk);
        sw_en = 1'b1; sw_wr_rd = 1'b1; sw_addr = 8'h03; sw_wdata = 8'hC3;
        for (int e = 1; e <= 10; e++) begin
            @(posedge clk); #1;
            if (e == 6) sw_en = 1'b0;
            if (sw_ack === 1'b1) begin
                ack_cnt++;
                if (ack_cnt == 1) first_at = e;
                if (ack_cnt == 2) second_at = e;
            end
        end
        $display("held request: acks=%0d at edges %0d,%0d regs=%08h", ack_cnt, first_at, second_at, reg_data_out);
        vectors++;
        if (ack_cnt !== 2) begin
            miscompares++;
            $display("FAIL held_ack_count got=%0d exp=2", ack_cnt);
        end
        vectors++;
        if (first_at !== 2 || second_at !== 5) begin
            miscompares++;
            $display("FAIL held_ack_timing got=%0d,%0d exp=2,5", first_at, second_at);
        end
        vectors++;
        if (reg_data_out !== 32'hC35A2277) begin
            miscompares++;
            $display("FAIL held_regs got=%08h exp=c35a2277", reg_data_out);
        end
        // Drop the request after acceptance and scramble the inputs. The
        // latched write must still commit.
        @(negedge clk);
        sw_en = 1'b1; sw_wr_rd = 1'b1; sw_addr = 8'h01; sw_wdata = 8'h4D;
        @(posedge clk); #1;
        sw_en = 1'b0; sw_wr_rd = 1'b0; sw_addr = 8'h10; sw_wdata = 8'hEE;
        @(posedge clk); #1;
        $display("dropped request: ack=%0b upd=%04b regs=%08h", sw_ack, reg_upd, reg_data_out);
        vectors++;
        if ({sw_ack, sw_err, reg_upd, reg_data_out} !== {1'b1, 1'b0, 4'b0010, 32'hC35A4D77}) begin
            miscompares++;
            $display("FAIL drop_en got ack=%0b err=%0b upd=%04b regs=%08h exp 1 0 0010 c35a4d77",
                     sw_ack, sw_err, reg_upd, reg_data_out);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        logic a1, e1, a2;
        logic [W-1:0] rd;
        logic [NREG-1:0] u1, u2;
        logic [NREG*W-1:0] rg;
        @(negedge clk);
        sw_en = 1'b1; sw_wr_rd = 1'b1; sw_addr = 8'h01; sw_wdata = 8'hFF;
        @(posedge clk); #1;
        sw_en = 1'b0;
        // Now in ACCESS: pulse reset between edges.
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        $display("reset in ACCESS: ack=%0b upd=%04b regs=%08h", sw_ack, reg_upd, reg_data_out);
        vectors++;
        if ({sw_ack, reg_upd} !== 5'b0) begin
            miscompares++;
            $display("FAIL rst_mid_ack got ack=%0b upd=%04b exp 0 0000", sw_ack, reg_upd);
        end
        vectors++;
        if (reg_data_out !== RV) begin
            miscompares++;
            $display("FAIL rst_mid_regs got=%08h exp=%08h", reg_data_out, RV);
        end
        // The FSM must be back in IDLE, so a fresh read acks on schedule.
        run_txn(1'b0, 8'h01, 8'h00, a1, e1, rd, u1, rg, a2, u2);
        vectors++;
        if ({a1, e1, rd} !== {1'b1, 1'b0, 8'h22}) begin
            miscompares++;
            $display("FAIL rst_mid_idle got ack=%0b err=%0b rdata=%02h exp 1 0 22", a1, e1, rd);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_write_read();
        test_lock();
        test_bad_addr();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cfg_reg_bank.md
# cfg_reg_bank

Parametrised configuration register bank for the switch. It replaces the fixed four-register, one-hot-write bank with an addressed read/write slave interface that has a request/acknowledge handshake. It adds per-register reset values, error reporting, a write-lock register and per-register update strobes. It sits between the host configuration port and the switch port logic, which consumes the flat `reg_data_out` bus.

## Interface
- `NUM_OF_REG`, default 4: number of config registers, 1..64.
- `W_WIDTH`, default 8: register and data width, minimum 8.
- `ADDR_WIDTH`, default 8: address width; must satisfy 2^ADDR_WIDTH > NUM_OF_REG.
- `LOCK_ADDR`, default {ADDR_WIDTH{1'b1}}: address of the lock register; must be ≥ NUM_OF_REG.
- `RST_VAL`, default 0: flat NUM_OF_REG*W_WIDTH reset values; register i resets to bits [i*W_WIDTH +: W_WIDTH].
- `clk`  input  1  single clock; all logic is rising-edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `sw_en`  input  1  transaction request; held high until `sw_ack` is seen.
- `sw_wr_rd`  input  1  1 = write, 0 = read.
- `sw_addr`  input  ADDR_WIDTH  register address; register i sits at address i.
- `sw_wdata`  input  W_WIDTH  write data.
- `sw_rdata`  output  W_WIDTH  read data, valid while `sw_ack`=1.
- `sw_ack`  output  1  one-cycle transaction-complete pulse.
- `sw_err`  output  1  error flag, valid while `sw_ack`=1.
- `reg_data_out`  output  NUM_OF_REG*W_WIDTH  current register contents; register i is at [i*W_WIDTH +: W_WIDTH].
- `reg_upd`  output  NUM_OF_REG  bit i pulses for one cycle when register i is written.

## Operation
- FSM states: IDLE, ACCESS, DONE.
  - IDLE → ACCESS when `sw_en`=1. On this transition, latch `sw_addr`, `sw_wr_rd` and `sw_wdata`.
  - ACCESS → DONE unconditionally. In ACCESS, execute the latched command and register the outputs `sw_ack`=1, `sw_err` and `sw_rdata`.
  - DONE → IDLE unconditionally. `sw_en` is ignored in DONE, so a request still held high cannot retrigger.
- Write to address i < NUM_OF_REG:
  - Unlocked: the register takes the latched data, `reg_upd[i]`=1 and `sw_err`=0.
  - Locked: the register is unchanged, no `reg_upd` and `sw_err`=1.
- Write to LOCK_ADDR:
  - W_WIDTH'hA5 sets `locked`=1.
  - W_WIDTH'h00 sets `locked`=0.
  - Any other value leaves `locked` unchanged.
  - All cases give `sw_err`=0. A lock write is never itself refused.
- Read from address i < NUM_OF_REG: `sw_rdata` = register i, `sw_err`=0. Reads are allowed while locked.
- Read from LOCK_ADDR: `sw_rdata` = {(W_WIDTH-1)'b0, locked}, `sw_err`=0.
- Any other address: `sw_err`=1 and no state change. A read returns `sw_rdata`=0.
- `sw_rdata` is 0 outside the ack cycle. The same holds for `sw_err`.
- `reg_data_out` is driven directly from the register flops, with no output mux stage.

## Timing
- Reset (asynchronous, `rst_n`=0):
  - FSM goes to IDLE.
  - Register i = RST_VAL slice i.
  - `locked`=0.
  - `sw_ack`, `sw_err`, `sw_rdata` and `reg_upd` are all 0.
- The request is sampled at edge k. The commit happens at edge k+1: the register update, `reg_upd` and `sw_ack` become visible after k+1. At edge k+2, `sw_ack` and `reg_upd` return to 0.
- Latency from request to ack is 2 cycles. Minimum spacing between transactions is 3 cycles.
- `sw_addr`, `sw_wr_rd` and `sw_wdata` need only be stable at edge k, because they are latched. Deasserting `sw_en` during ACCESS does not abort the transaction.
- If `sw_en` is still high when the FSM re-enters IDLE (after edge k+2), a new transaction starts at edge k+3.
- Reset asserted in ACCESS or DONE:
  - The transaction is dropped and no ack is produced.
  - Registers return to RST_VAL.
  - Any pending `reg_upd` is cleared.
- An unlock write and a subsequent config write need two separate transactions. Lock state takes effect for the transaction following the lock write.

## Test plan
- Reset: RST_VAL=32'h44332211, release `rst_n` → `reg_data_out`=32'h44332211, `sw_ack`=0, lock read returns 8'h00.
- Write then read:
  - Write 8'h5A to addr 2 → `sw_ack` 2 cycles after the request, `reg_upd`=4'b0100 in the same cycle, bits [23:16]=8'h5A.
  - Read addr 2 → `sw_rdata`=8'h5A, `sw_err`=0.
- Lock:
  - Write 8'hA5 to 8'hFF, then write 8'h77 to addr 0 → `sw_err`=1, register 0 unchanged, no `reg_upd`.
  - Write 8'h00 to 8'hFF, then write 8'h77 to addr 0 → `sw_err`=0 and the register is updated.
- Bad address: read 8'h10 → `sw_err`=1, `sw_rdata`=0. Write 8'h10 → `sw_err`=1, all registers unchanged.
- Handshake: hold `sw_en` high for 6 cycles on a write → exactly two acks, 3 cycles apart. Drop `sw_en` one cycle after the request → the write still commits.
- Reset mid-transaction: pulse `rst_n` low during ACCESS of a write 8'hFF to addr 1 → no ack, register 1 = RST_VAL slice 1, FSM in IDLE.
